regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two sources:
  - the main pipeline writeback (source A), which cannot be back-pressured;
  - a long-latency result source (source B: FP/div unit), which uses a valid/ready handshake.
- Source B results wait in a small FIFO and are written in idle write slots.
- A starvation counter requests a one-cycle pipeline stall so that B always drains.
- Sits between the WB stage / long-latency unit and the register file write port (wen, wa, wd, floatingWB).

Parameters:
- DEPTH, 4: source B FIFO entries; power of two, at least 2.
- MAX_WAIT, 8: consecutive cycles the FIFO head may be denied before a stall is requested; at least 1.

Ports:
- clock  in  1  system clock; all state updates on the posedge.
- reset  in  1  asynchronous, active-low reset.
- a_wen  in  1  source A write request.
- a_wa  in  5  source A register address.
- a_wd  in  32  source A write data.
- a_fp  in  1  source A targets the FP bank.
- b_valid  in  1  source B result valid.
- b_ready  out  1  source B result accepted this cycle when b_valid is also high.
- b_wa  in  5  source B register address.
- b_wd  in  32  source B write data.
- b_fp  in  1  source B targets the FP bank.
- rf_wen  out  1  to register file wen.
- rf_wa  out  5  to register file wa.
- rf_wd  out  32  to register file wd.
- rf_fp  out  1  to register file floatingWB.
- stall_req  out  1  registered; pipeline freezes its WB stage for this cycle.
- b_count  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (reset low, async):
  - FIFO pointers, occupancy and wait counter are cleared; stall_req=0.
  - b_ready is forced 0 while reset is low.
  - rf_wen=0 and rf_wa/rf_wd/rf_fp=0, because the FIFO is empty and A is ignored while in reset.
- A slot is "A-active" when a_wen=1 and a_wa!=0. A write with a_wa=0 is discarded and the slot is idle.
- Grant priority for the write port each cycle (rf_* outputs are combinational):
  1. stall_req=1: FIFO head is granted; a_* is ignored, since the pipeline re-presents it next cycle.
  2. A-active: A is granted.
  3. FIFO non-empty: FIFO head is granted.
  4. Otherwise rf_wen=0.
- Pop: the FIFO head pops on the clock edge of any cycle it is granted.
- Push:
  - b_ready = !full, with full meaning occupancy == DEPTH.
  - A push occurs when b_valid && b_ready.
  - No push while full, even if a pop occurs the same cycle.
- Push and pop in the same cycle leaves occupancy unchanged.
- Pointers wrap modulo DEPTH. b_count is in the range 0..DEPTH.
- Write order: B results are written in acceptance order. Order relative to A is not guaranteed.
  - The hazard unit uses b_count!=0 together with its own tags.
- Wait counter:
  - Cleared when the FIFO is empty or the head pops.
  - Otherwise incremented each cycle the head is denied, saturating at MAX_WAIT.
- stall_req:
  - Set on the edge where the counter is MAX_WAIT-1 and the head is denied again.
  - Cleared on the following edge, so it is exactly one cycle high.
  - It is never high with an empty FIFO.
- Latency: a B result accepted in cycle N is written at the earliest in cycle N+1, subject to the optional feature below.
- Reset asserted mid-operation flushes all FIFO contents; queued results are lost by design.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - When the FIFO is empty, stall_req=0, the slot is not A-active and b_valid=1, source B is written in the same cycle directly from b_*.
  - The result is not pushed; b_ready=1 in that cycle.
  - Zero-cycle latency.
- Undefined: all B results pass through the FIFO, with minimum latency 1.

Test Plan:
- Idle A, B sends wa=5 wd=0xAAAA5555 fp=1 in cycle N -> rf_wen=1, rf_wa=5, rf_fp=1 in cycle N+1 (cycle N if WB_BYPASS_EN); b_count returns to 0.
- A active every cycle (wa=3); B pushes 5 results with DEPTH=4 -> b_ready=0 after the 4th accept, b_count=4, A always granted.
- Continuing that case with MAX_WAIT=8 -> stall_req high exactly 1 cycle, 8 cycles after the head entered; the head is written that cycle with a_* ignored; b_count=3 afterward.
- a_wen=1, a_wa=0 with a non-empty FIFO -> FIFO head is granted in that slot.
- Simultaneous push and pop at b_count=2 -> b_count stays 2; data is written in FIFO order with pointers wrapping past DEPTH-1.
- Assert reset with b_count=3 and stall_req pending -> immediately b_count=0, stall_req=0, rf_wen=0, b_ready=0; after release b_ready=1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the
// pipeline writeback (source A, never back-pressured) and a long-latency
// result source (source B, valid/ready) buffered in a small FIFO.
// A starvation counter raises a one-cycle stall_req so queued B results
// always drain.
// Optional build macro WB_BYPASS_EN: when the FIFO is empty, no stall is
// pending and the slot is not A-active, a valid B result is written in the
// same cycle straight from b_* instead of being queued.
module regfile_wb_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         a_wen,
  input  logic [4:0]                   a_wa,
  input  logic [31:0]                  a_wd,
  input  logic                         a_fp,
  input  logic                         b_valid,
  output logic                         b_ready,
  input  logic [4:0]                   b_wa,
  input  logic [31:0]                  b_wd,
  input  logic                         b_fp,
  output logic                         rf_wen,
  output logic [4:0]                   rf_wa,
  output logic [31:0]                  rf_wd,
  output logic                         rf_fp,
  output logic                         stall_req,
  output logic [$clog2(DEPTH+1)-1:0]   b_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  // Handshake: a B result transfers on a rising clock edge when b_valid and
  // b_ready are both high; b_ready depends only on FIFO fullness (and is
  // held low during reset), never on b_valid.

  // Entry layout: {fp, wa[4:0], wd[31:0]}
  logic [37:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          stall_q, stall_d;

  logic          empty, full, a_act, head_grant, push, pop, bypass;
  logic [37:0]   head;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  // A is ignored while reset is asserted so the write port stays quiet.
  assign a_act = reset && a_wen && (a_wa != 5'd0);
  assign head  = mem_q[rd_ptr_q];

  // A pending stall overrides A (the pipeline re-presents A next cycle).
  assign head_grant = !empty && (stall_q || !a_act);
  assign pop        = head_grant;

`ifdef WB_BYPASS_EN
  assign bypass = reset && empty && !stall_q && !a_act && b_valid;
`else
  assign bypass = 1'b0;
`endif

  // When bypassing, the FIFO is empty so b_ready is already high.
  assign b_ready = reset && !full;
  assign push    = b_valid && b_ready && !bypass;

  // Write-port mux: stall-forced head, then A, then FIFO head, then bypass.
  always_comb begin
    rf_wen = 1'b0;
    rf_wa  = 5'd0;
    rf_wd  = 32'd0;
    rf_fp  = 1'b0;
    if (head_grant) begin
      rf_wen = 1'b1;
      rf_fp  = head[37];
      rf_wa  = head[36:32];
      rf_wd  = head[31:0];
    end else if (a_act) begin
      rf_wen = 1'b1;
      rf_wa  = a_wa;
      rf_wd  = a_wd;
      rf_fp  = a_fp;
    end else if (bypass) begin
      rf_wen = 1'b1;
      rf_wa  = b_wa;
      rf_wd  = b_wd;
      rf_fp  = b_fp;
    end
  end

  // Next-state for pointers, occupancy, starvation counter and stall.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wait_d   = wait_q;
    stall_d  = 1'b0;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (empty || pop) begin
      wait_d = '0;
    end else if (wait_q != WW'(MAX_WAIT)) begin
      wait_d = wait_q + WW'(1);
    end
    stall_d = !empty && !pop && (wait_q == WW'(MAX_WAIT - 1));
  end

  // Control state registers with asynchronous flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wait_q   <= '0;
      stall_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wait_q   <= wait_d;
      stall_q  <= stall_d;
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {b_fp, b_wa, b_wd};
  end

  assign stall_req = stall_q;
  assign b_count   = count_q;

endmodule
